// File: rtl/mem_req_ctrl.sv
// mem_req_ctrl: valid/ready request front-end that drives a single-port synchronous memory and returns read data
module mem_req_ctrl #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8,
  parameter int RD_LAT     = 1
) (
  input  logic                  i_w_clk,
  input  logic                  i_w_rst,
  input  logic                  i_w_req_valid,
  output logic                  o_w_req_ready,
  input  logic                  i_w_req_we,
  input  logic [ADDR_WIDTH-1:0] i_w_req_addr,
  input  logic [DATA_WIDTH-1:0] i_w_req_wdata,
  output logic                  o_w_rsp_valid,
  input  logic                  i_w_rsp_ready,
  output logic [DATA_WIDTH-1:0] o_w_rsp_rdata,
  output logic                  o_w_mem_cs,
  output logic                  o_w_mem_we,
  output logic [ADDR_WIDTH-1:0] o_w_mem_addr,
  output logic [DATA_WIDTH-1:0] o_w_mem_wdata,
  input  logic [DATA_WIDTH-1:0] i_w_mem_rdata
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
  state_t state;
  logic [1:0] cnt;
  logic cs;
  assign o_w_req_ready = state == IDLE;
  assign o_w_mem_cs = cs & ~i_w_rst;
  always_ff @(posedge i_w_clk) begin
    if (i_w_rst) begin
      state <= IDLE;
      cnt <= '0;
      cs <= 1'b0;
      o_w_mem_we <= 1'b0;
      o_w_mem_addr <= '0;
      o_w_mem_wdata <= '0;
      o_w_rsp_valid <= 1'b0;
      o_w_rsp_rdata <= '0;
    end else begin
      case (state)
        IDLE: if (i_w_req_valid) begin
          cs <= 1'b1;
          o_w_mem_we <= i_w_req_we;
          o_w_mem_addr <= i_w_req_addr;
          o_w_mem_wdata <= i_w_req_wdata;
          state <= ISSUE;
        end
        ISSUE: begin
          cs <= 1'b0;
          o_w_mem_we <= 1'b0;
          cnt <= 2'(RD_LAT - 1);
          state <= o_w_mem_we ? IDLE : WAIT;
        end
        WAIT: if (cnt == 2'd0) begin
          o_w_rsp_rdata <= i_w_mem_rdata;
          o_w_rsp_valid <= 1'b1;
          state <= RESP;
        end else begin
          cnt <= cnt - 2'd1;
        end
        RESP: if (i_w_rsp_ready) begin
          o_w_rsp_valid <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end
endmodule
